led_matrix_driver: RTL and testbench

// - Drives a row-scanned 8x8 LED matrix from a 64-bit framebuffer produced by map_generator (sibling block).
// - Scans one row at a time, with a programmable dwell and a blanking window that suppresses ghosting.
// - The framebuffer is latched once per frame so the display never shows a torn image.
// - Sits between map_generator and the board pins: row[7:0], col[7:0].

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/led_matrix_driver_if.sv | 22 ++
 rtl/led_matrix_driver_scan_timer.sv | 80 ++++++++
 rtl/led_matrix_driver.sv | 76 +++++++
 tb/tb_led_matrix_driver.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg
// Shared geometry, types and pixel indexing for the 8x8 LED matrix blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FB_W        = 64;
  localparam int ROW_W       = 3;

  typedef logic [ROW_W-1:0] row_idx_t;

  // SCAN_LOAD is the single post-reset cycle that loads the first frame
  // without advancing the counters.
  typedef enum logic [0:0] {
    SCAN_LOAD = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  // Pixel (r,c) lives at bit 8*r + c of the framebuffer.
  function automatic logic [5:0] idx(input row_idx_t r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_matrix_driver_if.sv
// ============================================================================
// led_matrix_driver_if
// Framebuffer input and row/column pin outputs of the matrix driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_matrix_driver_if;
  import matrix_pkg::*;

  logic [FB_W-1:0]        framebuffer;
  logic [MATRIX_ROWS-1:0] row;
  logic [MATRIX_COLS-1:0] col;

  // Producer side: supplies pixels, observes the pins.
  modport master (output framebuffer, input row, input col);
  // Driver side: consumes pixels, drives the pins.
  modport slave  (input framebuffer, output row, output col);

endinterface

`default_nettype wire

// File: rtl/led_matrix_driver_scan_timer.sv
// ============================================================================
// scan_timer
// Row dwell divider and row counter. Outputs are the next-state values so the
// caller can register its outputs on the same edge without extra lag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_timer
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic     system_clk,
  input  logic     rst,
  output row_idx_t row_idx_o,
  output logic     blank_o,
  output logic     frame_start_o
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  scan_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  row_idx_t         row_idx_q, row_idx_d;
  logic             div_wrap;

  // State and counter registers; reset parks at row 0, divider 0.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN_LOAD;
      div_cnt_q <= '0;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      row_idx_q <= row_idx_d;
    end
  end

  // Next-state: the load cycle holds the counters at 0 so it counts as the
  // first clock of row 0; afterwards the divider runs and bumps the row.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    row_idx_d     = row_idx_q;
    div_wrap      = (div_cnt_q == DIV_LAST);
    frame_start_o = 1'b0;
    case (state_q)
      SCAN_LOAD: begin
        state_d       = SCAN_RUN;
        frame_start_o = 1'b1;
      end
      default: begin
        if (div_wrap) begin
          div_cnt_d     = '0;
          row_idx_d     = row_idx_q + 1'b1;
          frame_start_o = (row_idx_q == row_idx_t'(MATRIX_ROWS - 1));
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign row_idx_o = row_idx_d;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_o = 1'b0;
    end else begin : g_blank
      assign blank_o = (div_cnt_d < DIV_W'(BLANK_CYCLES));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/led_matrix_driver.sv
// ============================================================================
// led_matrix_driver
// Row-scanned 8x8 LED matrix driver with per-frame shadow framebuffer and a
// blanking window at the start of every row.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_matrix_driver
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ROW_ACT_LOW  = 1'b0,
  parameter bit COL_ACT_LOW  = 1'b1
) (
  input  logic               system_clk,
  input  logic               rst,
  led_matrix_driver_if.slave bus
);

  localparam logic [MATRIX_ROWS-1:0] ROW_OFF = {MATRIX_ROWS{ROW_ACT_LOW}};
  localparam logic [MATRIX_COLS-1:0] COL_OFF = {MATRIX_COLS{COL_ACT_LOW}};

  row_idx_t               row_idx;
  logic                   blank;
  logic                   frame_start;
  logic [FB_W-1:0]        shadow_q, shadow_d;
  logic [MATRIX_ROWS-1:0] row_q, row_d;
  logic [MATRIX_COLS-1:0] col_q, col_d;
  logic [MATRIX_COLS-1:0] row_pixels;
  logic [MATRIX_ROWS-1:0] row_onehot;

  scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .system_clk    (system_clk),
    .rst           (rst),
    .row_idx_o     (row_idx),
    .blank_o       (blank),
    .frame_start_o (frame_start)
  );

  // Output data: a frame-start edge displays the framebuffer being latched.
  always_comb begin
    shadow_d   = frame_start ? bus.framebuffer : shadow_q;
    row_pixels = shadow_d[idx(row_idx, 3'd0) +: MATRIX_COLS];
    row_onehot = {{(MATRIX_ROWS-1){1'b0}}, 1'b1} << row_idx;
    row_d      = ROW_OFF;
    col_d      = COL_OFF;
    if (!blank) begin
      row_d = row_onehot ^ ROW_OFF;
      col_d = row_pixels ^ COL_OFF;
    end
  end

  // Shadow and pin registers; reset drives every pin inactive immediately.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      row_q    <= ROW_OFF;
      col_q    <= COL_OFF;
    end else begin
      shadow_q <= shadow_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign bus.row = row_q;
  assign bus.col = col_q;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_driver.sv
// ============================================================================
// tb_led_matrix_driver
// Scoreboard bench for led_matrix_driver: a blanking instance (BLANK_CYCLES=2)
// and a no-blank instance (BLANK_CYCLES=0) run side by side, SCAN_DIV=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_matrix_driver;
  import matrix_pkg::*;

  localparam logic [63:0] PAT = 64'h0102040810204080;

  typedef struct packed {
    logic [7:0] ra;
    logic [7:0] ca;
    logic [7:0] rb;
    logic [7:0] cb;
  } exp_t;

  logic system_clk = 1'b0;
  logic rst        = 1'b0;

  led_matrix_driver_if bus_a ();
  led_matrix_driver_if bus_b ();

  led_matrix_driver #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .ROW_ACT_LOW  (1'b0),
    .COL_ACT_LOW  (1'b1)
  ) dut_a (
    .system_clk (system_clk),
    .rst        (rst),
    .bus        (bus_a)
  );

  led_matrix_driver #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (0),
    .ROW_ACT_LOW  (1'b0),
    .COL_ACT_LOW  (1'b1)
  ) dut_b (
    .system_clk (system_clk),
    .rst        (rst),
    .bus        (bus_b)
  );

  always #5 system_clk = ~system_clk;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  int          k;
  logic [63:0] sfb;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pins after edge kk of the scan (kk=1 is the first edge after
  // reset release): edge kk sits at divider phase (kk-1)%8 of row
  // ((kk-1)/8)%8; phases 0-1 are blanked on instance A only.
  function automatic exp_t model(input logic rst_v, input int kk, input logic [63:0] fb);
    exp_t       e;
    int         phase;
    int         r;
    logic [7:0] pix;
    e = '{ra: 8'h00, ca: 8'hFF, rb: 8'h00, cb: 8'hFF};
    if (!rst_v) begin
      phase = (kk - 1) % 8;
      r     = ((kk - 1) / 8) % 8;
      pix   = fb[8*r +: 8];
      e.rb  = 8'h01 << r;
      e.cb  = ~pix;
      if (phase >= 2) begin
        e.ra = 8'h01 << r;
        e.ca = ~pix;
      end
    end
    return e;
  endfunction

  // One clock of stimulus: drive between edges, queue what the next edge
  // must produce. The frame image is whatever is presented on a frame-start edge.
  task automatic step(input logic rst_v, input logic [63:0] fb_v);
    @(negedge system_clk);
    #1;
    rst               = rst_v;
    bus_a.framebuffer = fb_v;
    bus_b.framebuffer = fb_v;
    if (rst_v) begin
      k = 0;
    end else begin
      k++;
      if ((k - 1) % 64 == 0) sfb = fb_v;
    end
    sb.push_back(model(rst_v, k, sfb));
  endtask

  // Monitor: the pins are sampled mid-cycle, after the edge they reflect.
  always @(negedge system_clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check8("row_a", bus_a.row, e.ra);
      check8("col_a", bus_a.col, e.ca);
      check8("row_b", bus_b.row, e.rb);
      check8("col_b", bus_b.col, e.cb);
      n_vec++;
      if ($countones(bus_a.row) > 1 || $countones(bus_b.row) > 1) begin
        n_bad++;
        $display("FAIL onehot: got row_a=%02h row_b=%02h expected at most one bit", bus_a.row, bus_b.row);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    k                 = 0;
    sfb               = '0;
    bus_a.framebuffer = '1;
    bus_b.framebuffer = '1;

    // Reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check8("rst_now_row_a", bus_a.row, 8'h00);
    check8("rst_now_col_a", bus_a.col, 8'hFF);
    check8("rst_now_row_b", bus_b.row, 8'h00);
    check8("rst_now_col_b", bus_b.col, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b1, '1);

    // Release: two full frames plus part of a third; the framebuffer drops
    // to zero inside row 3 of frame 2 and only shows from frame 3.
    for (int i = 1; i <= 89; i++) step(1'b0, PAT);
    for (int i = 90; i <= 163; i++) step(1'b0, (i < 150) ? 64'h0 : PAT);

    // Asynchronous reset between edges in row 4 of frame 3.
    @(negedge system_clk);
    #3;
    rst               = 1'b1;
    bus_a.framebuffer = '1;
    bus_b.framebuffer = '1;
    #1;
    check8("async_rst_row_a", bus_a.row, 8'h00);
    check8("async_rst_col_a", bus_a.col, 8'hFF);
    check8("async_rst_row_b", bus_b.row, 8'h00);
    check8("async_rst_col_b", bus_b.col, 8'hFF);
    k = 0;
    for (int i = 0; i < 3; i++) step(1'b1, '1);

    // Restart: fresh load, row 0 after the blanking window.
    for (int i = 0; i < 20; i++) step(1'b0, PAT);

    @(negedge system_clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
